// File: rtl/traceback_processing.sv
// Needleman-Wunsch traceback step: turns one direction symbol plus the current (i,j)
// characters into an aligned character pair and a saturating running alignment score.
module traceback_processing #(
    parameter int         MATCH    = 1,
    parameter int         MISMATCH = -1,
    parameter int         GAP      = -2,
    parameter logic [2:0] GAP_CODE = 3'b111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_traceB,
    input  logic [2:0] SeqA_i_t,
    input  logic [2:0] SeqB_j_t,
    input  logic [2:0] symbol,
    output logic [8:0] final_score,
    output logic [2:0] datoA,
    output logic [2:0] datoB
);

    localparam int DATA_W  = 3;
    localparam int SCORE_W = 9;

    // Clamp a 10-bit sum into the 9-bit signed score range; bits 9 and 8 differ only on overflow.
    function automatic logic signed [SCORE_W-1:0] sat_score(input logic signed [SCORE_W:0] v);
        if (v[SCORE_W] == v[SCORE_W-1])
            return v[SCORE_W-1:0];
        else if (v[SCORE_W])
            return {1'b1, {(SCORE_W-1){1'b0}}};
        else
            return {1'b0, {(SCORE_W-1){1'b1}}};
    endfunction

    logic                      step_p0;
    logic [DATA_W-1:0]         dato_a_p0;
    logic [DATA_W-1:0]         dato_b_p0;
    logic signed [SCORE_W:0]   delta_p0;
    logic signed [SCORE_W:0]   base_p0;
    logic signed [SCORE_W:0]   sum_p0;

    logic                      run_p1;
    logic signed [SCORE_W-1:0] score_p1;
    logic [DATA_W-1:0]         dato_a_p1;
    logic [DATA_W-1:0]         dato_b_p1;

    // Stage p0: decode the step and form the unclamped next score.
    always_comb begin
        step_p0   = en_traceB &&
                    ((symbol == 3'b001) || (symbol == 3'b010) || (symbol == 3'b100));
        dato_a_p0 = SeqA_i_t;
        dato_b_p0 = SeqB_j_t;
        delta_p0  = 10'(GAP);
        case (symbol)
            3'b001:  delta_p0  = (SeqA_i_t == SeqB_j_t) ? 10'(MATCH) : 10'(MISMATCH);
            3'b010:  dato_b_p0 = GAP_CODE;
            3'b100:  dato_a_p0 = GAP_CODE;
            default: ;
        endcase
        // A fresh traceback starts from zero rather than the held score.
        base_p0 = run_p1 ? {score_p1[SCORE_W-1], score_p1} : '0;
        sum_p0  = base_p0 + delta_p0;
    end

    // Stage p1: registered outputs and run flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_p1    <= 1'b0;
            score_p1  <= '0;
            dato_a_p1 <= '0;
            dato_b_p1 <= '0;
        end else if (!en_traceB) begin
            run_p1 <= 1'b0;
        end else if (step_p0) begin
            run_p1    <= 1'b1;
            score_p1  <= sat_score(sum_p0);
            dato_a_p1 <= dato_a_p0;
            dato_b_p1 <= dato_b_p0;
        end
    end

    assign final_score = score_p1;
    assign datoA       = dato_a_p1;
    assign datoB       = dato_b_p1;

endmodule

// File: tb/tb_traceback_processing.sv
// Directed bench for traceback_processing: a behavioural score model feeds a scoreboard
// queue at drive time; entries are popped and checked one cycle later.
module tb_traceback_processing;

    localparam logic [2:0] CH_A = 3'b100;
    localparam logic [2:0] CH_C = 3'b110;
    localparam logic [2:0] CH_G = 3'b001;
    localparam logic [2:0] CH_T = 3'b011;
    localparam logic [2:0] GAPC = 3'b111;
    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_traceB = 1'b0;
    logic [2:0] SeqA_i_t = '0;
    logic [2:0] SeqB_j_t = '0;
    logic [2:0] symbol = '0;
    logic [8:0] final_score;
    logic [2:0] datoA;
    logic [2:0] datoB;

    traceback_processing dut (
        .clk        (clk),
        .rst        (rst),
        .en_traceB  (en_traceB),
        .SeqA_i_t   (SeqA_i_t),
        .SeqB_j_t   (SeqB_j_t),
        .symbol     (symbol),
        .final_score(final_score),
        .datoA      (datoA),
        .datoB      (datoB)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] score;
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int         m_score = 0;
    bit         m_run   = 1'b0;
    logic [2:0] m_a     = '0;
    logic [2:0] m_b     = '0;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: integer score with explicit clamping.
    task automatic model_step(input logic en, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] sym);
        int d;
        if (!en) begin
            m_run = 1'b0;
        end else if (sym == DIAG || sym == UP || sym == LEFT) begin
            d = (sym == DIAG) ? ((a == b) ? 1 : -1) : -2;
            m_score = m_run ? m_score + d : d;
            if (m_score > 255)  m_score = 255;
            if (m_score < -256) m_score = -256;
            m_a   = (sym == LEFT) ? GAPC : a;
            m_b   = (sym == UP)   ? GAPC : b;
            m_run = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_run = 1'b0; m_a = '0; m_b = '0;
    endtask

    task automatic drive(input logic en, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] sym);
        en_traceB = en; SeqA_i_t = a; SeqB_j_t = b; symbol = sym;
    endtask

    task automatic pop_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: observed 0 entries, required 1");
        end else begin
            e = q.pop_front();
            check({e.tag, "_score"}, final_score, e.score);
            check({e.tag, "_A"}, {6'd0, datoA}, {6'd0, e.a});
            check({e.tag, "_B"}, {6'd0, datoB}, {6'd0, e.b});
        end
    endtask

    // Step whose expectation comes from the model.
    task automatic step(input string tag, input logic en, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] sym);
        drive(en, a, b, sym);
        model_step(en, a, b, sym);
        q.push_back('{tag, 9'(m_score), m_a, m_b});
        pop_check();
    endtask

    // Step whose expectation is a hand-derived constant.
    task automatic step_k(input string tag, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] sym, input logic [2:0] ea, input logic [2:0] eb,
                          input int es);
        drive(1'b1, a, b, sym);
        model_step(1'b1, a, b, sym);
        q.push_back('{tag, 9'(es), ea, eb});
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset held with random inputs, then idle with enable low.
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            q.push_back('{"rst_hold", 9'd0, 3'd0, 3'd0});
            pop_check();
        end
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++)
            step("en_low", 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));

        // Test 2: enabled with a null symbol is a no-op.
        for (int i = 0; i < 10; i++)
            step_k("idle_sym0", CH_A, CH_C, 3'b000, 3'd0, 3'd0, 0);

        // Test 3: CACTG vs GATGC traceback.
        step_k("tb_left",  CH_G, CH_C, LEFT, GAPC, CH_C, -2);
        step_k("tb_diag1", CH_G, CH_G, DIAG, CH_G, CH_G, -1);
        step_k("tb_diag2", CH_T, CH_T, DIAG, CH_T, CH_T, 0);
        step_k("tb_up",    CH_C, CH_A, UP,   CH_C, GAPC, -2);
        step_k("tb_diag3", CH_A, CH_A, DIAG, CH_A, CH_A, -1);
        step_k("tb_diag4", CH_C, CH_G, DIAG, CH_C, CH_G, -2);
        step("tb_hold", 1'b0, CH_T, CH_A, DIAG);

        // Test 4: restart discards the previous score.
        step_k("restart", CH_T, CH_T, DIAG, CH_T, CH_T, 1);

        // Multi-hot symbol holds everything including the run flag.
        step_k("multihot", CH_G, CH_A, 3'b110, CH_T, CH_T, 1);
        step_k("after_multihot", CH_A, CH_C, DIAG, CH_A, CH_C, 0);

        // Test 5: saturation in both directions.
        for (int i = 0; i < 300; i++) step("sat_neg", 1'b1, CH_G, CH_C, LEFT);
        check("sat_neg_final", final_score, 9'h100);
        step("sat_gap", 1'b0, CH_A, CH_A, DIAG);
        for (int i = 0; i < 300; i++) step("sat_pos", 1'b1, CH_G, CH_G, DIAG);
        check("sat_pos_final", final_score, 9'h0FF);
        step("sat_end", 1'b0, CH_A, CH_A, DIAG);

        // Test 6: asynchronous reset in the middle of a traceback.
        step_k("ar_left",  CH_G, CH_C, LEFT, GAPC, CH_C, -2);
        step_k("ar_diag1", CH_G, CH_G, DIAG, CH_G, CH_G, -1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_score", final_score, 9'd0);
        check("async_A", {6'd0, datoA}, 9'd0);
        check("async_B", {6'd0, datoB}, 9'd0);
        #1 rst = 1'b1;
        step_k("post_reset", CH_T, CH_T, DIAG, CH_T, CH_T, 1);
        step_k("post_reset2", CH_C, CH_A, UP, CH_C, GAPC, -1);

        check("queue_drained", 9'(q.size()), 9'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
